// File: rtl/pwm_capture.sv
// PWM receiver: measures on-time and period of a synchronized PWM input in tick units,
// with saturation reporting and a no-edge (stuck) timeout.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 65535,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] on_count,
  output logic [CNT_W-1:0] period_count,
  output logic             valid,
  output logic             overflow_err,
  output logic             stuck,
  output logic             stuck_level
);

  // The idle counter is sized from TIMEOUT so it never wraps before the timeout fires.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]    TO_VAL  = TW'(TIMEOUT);
  localparam logic [TW-1:0]    TO_M1   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, act_q;
  logic             act, rise, fall, edge_seen;
  logic [CNT_W-1:0] on_acc_q, on_acc_d, per_acc_q, per_acc_d;
  logic [CNT_W-1:0] on_count_q, on_count_d, period_count_q, period_count_d;
  logic             sat_q, sat_d, valid_q, valid_d, ovf_q, ovf_d;
  logic             stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic [CNT_W-1:0] on_inc, per_inc;
  logic             on_clip, per_clip, timeout_hit;

  assign act       = sync2_q ^ ACTIVE_LOW;
  assign rise      = act & ~act_q;
  assign fall      = ~act & act_q;
  assign edge_seen = rise | fall;

  always_comb begin
    on_clip     = tick && (on_acc_q == CNT_MAX);
    per_clip    = tick && (per_acc_q == CNT_MAX);
    on_inc      = (tick && !on_clip) ? on_acc_q + CNT_W'(1) : on_acc_q;
    per_inc     = (tick && !per_clip) ? per_acc_q + CNT_W'(1) : per_acc_q;
    timeout_hit = tick && !edge_seen && (idle_q == TO_M1);
  end

  always_comb begin
    state_d        = state_q;
    on_acc_d       = on_acc_q;
    per_acc_d      = per_acc_q;
    sat_d          = sat_q;
    on_count_d     = on_count_q;
    period_count_d = period_count_q;
    valid_d        = 1'b0;
    ovf_d          = 1'b0;
    stuck_d        = stuck_q;
    stuck_lvl_d    = stuck_lvl_q;

    if (edge_seen) begin
      idle_d = '0;
    end else if (tick && (idle_q != TO_VAL)) begin
      idle_d = idle_q + TW'(1);
    end else begin
      idle_d = idle_q;
    end

    if (edge_seen) begin
      stuck_d     = 1'b0;
      stuck_lvl_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        on_acc_d  = '0;
        per_acc_d = '0;
        sat_d     = 1'b0;
        if (rise) state_d = S_ON;
      end
      S_ON: begin
        on_acc_d  = on_inc;
        per_acc_d = per_inc;
        sat_d     = sat_q | on_clip | per_clip;
        if (fall) state_d = S_OFF;
      end
      S_OFF: begin
        per_acc_d = per_inc;
        sat_d     = sat_q | per_clip;
        if (rise) begin
          // The tick of the rise cycle closes the old period; the new one starts at 0.
          on_count_d     = on_acc_q;
          period_count_d = per_inc;
          valid_d        = 1'b1;
          ovf_d          = sat_q | per_clip;
          on_acc_d       = '0;
          per_acc_d      = '0;
          sat_d          = 1'b0;
          state_d        = S_ON;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      stuck_d     = 1'b1;
      stuck_lvl_d = act;
      state_d     = S_IDLE;
      on_acc_d    = '0;
      per_acc_d   = '0;
      sat_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= ACTIVE_LOW;
      sync2_q        <= ACTIVE_LOW;
      act_q          <= 1'b0;
      state_q        <= S_IDLE;
      on_acc_q       <= '0;
      per_acc_q      <= '0;
      sat_q          <= 1'b0;
      on_count_q     <= '0;
      period_count_q <= '0;
      valid_q        <= 1'b0;
      ovf_q          <= 1'b0;
      stuck_q        <= 1'b0;
      stuck_lvl_q    <= 1'b0;
      idle_q         <= '0;
    end else begin
      sync1_q        <= pwm_in;
      sync2_q        <= sync1_q;
      act_q          <= act;
      state_q        <= state_d;
      on_acc_q       <= on_acc_d;
      per_acc_q      <= per_acc_d;
      sat_q          <= sat_d;
      on_count_q     <= on_count_d;
      period_count_q <= period_count_d;
      valid_q        <= valid_d;
      ovf_q          <= ovf_d;
      stuck_q        <= stuck_d;
      stuck_lvl_q    <= stuck_lvl_d;
      idle_q         <= idle_d;
    end
  end

  assign on_count     = on_count_q;
  assign period_count = period_count_q;
  assign valid        = valid_q;
  assign overflow_err = ovf_q;
  assign stuck        = stuck_q;
  assign stuck_level  = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: three instances cover polarity, tick gating,
// 8-bit saturation, stuck timeout and mid-period reset.
module tb_pwm_capture;

  typedef struct {
    int on;
    int per;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  tick_v = 3'b111;
  logic [2:0]  pwm_v = 3'b101;
  logic        gate = 1'b0;
  int          tcnt = 0;

  logic [15:0] on0, per0, on1, per1;
  logic [7:0]  on2, per2;
  logic [2:0]  val, ovf, stk, stl;

  exp_t q0[$], q1[$], q2[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16), .TIMEOUT(200), .ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst_v[0]), .tick(tick_v[0]), .pwm_in(pwm_v[0]),
    .on_count(on0), .period_count(per0), .valid(val[0]), .overflow_err(ovf[0]),
    .stuck(stk[0]), .stuck_level(stl[0]));

  pwm_capture #(.CNT_W(16), .TIMEOUT(65535), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst_v[1]), .tick(tick_v[1]), .pwm_in(pwm_v[1]),
    .on_count(on1), .period_count(per1), .valid(val[1]), .overflow_err(ovf[1]),
    .stuck(stk[1]), .stuck_level(stl[1]));

  pwm_capture #(.CNT_W(8), .TIMEOUT(1000), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst(rst_v[2]), .tick(tick_v[2]), .pwm_in(pwm_v[2]),
    .on_count(on2), .period_count(per2), .valid(val[2]), .overflow_err(ovf[2]),
    .stuck(stk[2]), .stuck_level(stl[2]));

  task automatic cmp(string name, int got, int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push(int inst, int e_on, int e_per, bit e_ovf);
    exp_t e;
    e.on = e_on; e.per = e_per; e.ovf = e_ovf;
    case (inst)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(int inst, int got_on, int got_per, bit got_ovf);
    exp_t e;
    bit have = 1'b0;
    case (inst)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      total++;
      bad++;
      $display("FAIL unexpected_valid u%0d: got on=%0d per=%0d, required no valid",
               inst, got_on, got_per);
    end else begin
      cmp($sformatf("u%0d on_count", inst), got_on, e.on);
      cmp($sformatf("u%0d period_count", inst), got_per, e.per);
      cmp($sformatf("u%0d overflow_err", inst), int'(got_ovf), int'(e.ovf));
    end
  endtask

  // Monitor: sample 1 time unit after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (val[0]) mon(0, int'(on0), int'(per0), ovf[0]);
    if (val[1]) mon(1, int'(on1), int'(per1), ovf[1]);
    if (val[2]) mon(2, int'(on2), int'(per2), ovf[2]);
    for (int k = 0; k < 3; k++) begin
      if (ovf[k] && !val[k]) begin
        total++;
        bad++;
        $display("FAIL u%0d overflow_without_valid: got overflow_err=1, required 0", k);
      end
    end
  end

  // u0 tick: tied high, or one pulse every 501 clk when gated.
  initial begin
    forever begin
      @(negedge clk);
      if (gate) begin
        tick_v[0] = (tcnt == 0);
        tcnt = (tcnt == 500) ? 0 : tcnt + 1;
      end else begin
        tick_v[0] = 1'b1;
        tcnt = 0;
      end
    end
  end

  function automatic bit al(int inst);
    return (inst != 1);
  endfunction

  task automatic drive(int inst, bit a);
    pwm_v[inst] = a ^ al(inst);
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic period(int inst, int on_n, int off_n, int e_on, int e_per, bit e_ovf);
    push(inst, e_on, e_per, e_ovf);
    drive(inst, 1'b1); wait_clk(on_n);
    drive(inst, 1'b0); wait_clk(off_n);
  endtask

  // Final rise publishes the last pushed period.
  task automatic finish_run(int inst);
    drive(inst, 1'b1); wait_clk(8);
    drive(inst, 1'b0); wait_clk(5);
  endtask

  task automatic do_reset(int inst);
    drive(inst, 1'b0); wait_clk(5);
    rst_v[inst] = 1'b1; wait_clk(1);
    rst_v[inst] = 1'b0; wait_clk(3);
  endtask

  initial begin
    wait_clk(3);
    rst_v = 3'b000;
    wait_clk(1);
    cmp("reset on_count", int'(on0), 0);
    cmp("reset period_count", int'(per0), 0);
    cmp("reset valid", int'(val[0]), 0);
    cmp("reset stuck", int'(stk[0]), 0);

    // Basic 25/100 capture, active-low input, tick tied high.
    do_reset(0);
    for (int i = 0; i < 4; i++) period(0, 25, 75, 25, 100, 1'b0);
    finish_run(0);

    // Polarity and extremes on the active-high instance.
    do_reset(1);
    for (int i = 0; i < 3; i++) period(1, 1, 9, 1, 10, 1'b0);
    finish_run(1);
    do_reset(1);
    for (int i = 0; i < 3; i++) period(1, 9, 1, 9, 10, 1'b0);
    finish_run(1);

    // Saturation on 8 bits, then a normal period to show the flag clears.
    do_reset(2);
    period(2, 300, 20, 255, 255, 1'b1);
    period(2, 100, 20, 100, 120, 1'b0);
    finish_run(2);

    // Tick gating at two different edge phases.
    gate = 1'b1;
    do_reset(0);
    wait_clk(137);
    for (int i = 0; i < 3; i++) period(0, 1503, 2505, 3, 8, 1'b0);
    finish_run(0);
    do_reset(0);
    wait_clk(250);
    for (int i = 0; i < 2; i++) period(0, 1503, 2505, 3, 8, 1'b0);
    finish_run(0);
    gate = 1'b0;

    // Stuck: last edge then 200 ticks of no activity.
    do_reset(0);
    drive(0, 1'b1); wait_clk(25);
    drive(0, 1'b0); wait_clk(202);
    cmp("stuck before timeout", int'(stk[0]), 0);
    wait_clk(1);
    cmp("stuck at timeout", int'(stk[0]), 1);
    cmp("stuck_level", int'(stl[0]), 0);
    wait_clk(50);
    cmp("stuck held", int'(stk[0]), 1);
    push(0, 25, 100, 1'b0);
    drive(0, 1'b1); wait_clk(3);
    cmp("stuck cleared by edge", int'(stk[0]), 0);
    wait_clk(22);
    drive(0, 1'b0); wait_clk(75);
    period(0, 25, 75, 25, 100, 1'b0);
    finish_run(0);

    // Reset in the middle of the on segment.
    do_reset(0);
    period(0, 25, 75, 25, 100, 1'b0);
    drive(0, 1'b1); wait_clk(10);
    drive(0, 1'b0);
    rst_v[0] = 1'b1; wait_clk(1);
    rst_v[0] = 1'b0;
    cmp("midreset on_count", int'(on0), 0);
    cmp("midreset period_count", int'(per0), 0);
    cmp("midreset valid", int'(val[0]), 0);
    cmp("midreset overflow_err", int'(ovf[0]), 0);
    cmp("midreset stuck", int'(stk[0]), 0);
    cmp("midreset stuck_level", int'(stl[0]), 0);
    wait_clk(30);
    for (int i = 0; i < 2; i++) period(0, 25, 75, 25, 100, 1'b0);
    finish_run(0);

    wait_clk(10);
    cmp("u0 missing valids", q0.size(), 0);
    cmp("u1 missing valids", q1.size(), 0);
    cmp("u2 missing valids", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
